// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter width: must hold values 0 .. WIDTH/BITS_PER_CYCLE.
  function automatic int cnt_width(input int width, input int bpc);
    return $clog2(width / bpc + 1);
  endfunction

endpackage

// File: rtl/div_row.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor with a ripple of A + ~B + Cin cells, and
// keep the difference when there is no borrow, otherwise restore.
module div_row #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] p_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] p_out,
  output logic             q_bit
);

  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   b;
  logic [WIDTH-1:0] diff;
  logic             carry;

  assign sh = {p_in, bit_in};
  assign b  = ~{1'b0, d};

  // Ripple subtract over WIDTH+1 cells; the top cell only contributes its carry
  // because a kept difference is always below the divisor and fits in WIDTH bits.
  always_comb begin
    diff  = '0;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = sh[i] ^ b[i] ^ carry;
      carry   = (sh[i] & b[i]) | (sh[i] & carry) | (b[i] & carry);
    end
    q_bit = (sh[WIDTH] & b[WIDTH]) | (sh[WIDTH] & carry) | (b[WIDTH] & carry);
    p_out = q_bit ? diff : sh[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_restoring_div.sv
// Iterative restoring divider, BITS_PER_CYCLE quotient bits per clock.
// Handshake: a transfer happens on an input edge where in_valid && in_ready,
// and on an output edge where out_valid && out_ready; both ready/valid outputs
// come straight from the state register.
// Optional: define SEQ_DIV_SIGNED_EN for two's-complement operands
// (truncating quotient, remainder carries the dividend's sign).
module seq_restoring_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH          = 24,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;       // partial remainder
  logic [WIDTH-1:0] qr_q, qr_d;     // dividend bits in, quotient bits out
  logic [WIDTH-1:0] d_q, d_d;       // divisor magnitude
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;   // divide-by-zero flag of the op in flight
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_out_q, dbz_out_d;
  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] dv_mag;
  logic [WIDTH-1:0] fin_p;
  logic [WIDTH-1:0] fin_q;

`ifdef SEQ_DIV_SIGNED_EN
  logic sq_q, sq_d;   // quotient must be negated
  logic sr_q, sr_d;   // remainder must be negated
  assign dd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dv_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign dd_mag = dividend;
  assign dv_mag = divisor;
`endif

  // Chain of subtract-and-select rows resolving BITS_PER_CYCLE bits per clock.
  for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_stage
    logic [WIDTH-1:0] p_i, q_i, p_o, q_o;
    logic             qb;
    if (j == 0) begin : g_first
      assign p_i = p_q;
      assign q_i = qr_q;
    end else begin : g_next
      assign p_i = g_stage[j-1].p_o;
      assign q_i = g_stage[j-1].q_o;
    end
    div_row #(.WIDTH(WIDTH)) u_row (
      .p_in  (p_i),
      .bit_in(q_i[WIDTH-1]),
      .d     (d_q),
      .p_out (p_o),
      .q_bit (qb)
    );
    assign q_o = {q_i[WIDTH-2:0], qb};
  end

  assign fin_p = g_stage[BITS_PER_CYCLE-1].p_o;
  assign fin_q = g_stage[BITS_PER_CYCLE-1].q_o;

  // State register and datapath flops; reset discards any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      p_q       <= '0;
      qr_q      <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      dbz_q     <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_out_q <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      sq_q      <= 1'b0;
      sr_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      qr_q      <= qr_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      dbz_q     <= dbz_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_out_q <= dbz_out_d;
`ifdef SEQ_DIV_SIGNED_EN
      sq_q      <= sq_d;
      sr_q      <= sr_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)        state_d = RUN;
      RUN:     if (cnt_q == LAST)   state_d = DONE;
      DONE:    if (out_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath: load operands at accept, iterate in RUN, publish on the last step.
  always_comb begin
    p_d       = p_q;
    qr_d      = qr_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    dbz_d     = dbz_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_out_d = dbz_out_q;
`ifdef SEQ_DIV_SIGNED_EN
    sq_d      = sq_q;
    sr_d      = sr_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          p_d   = '0;
          qr_d  = dd_mag;
          d_d   = dv_mag;
          cnt_d = '0;
          dbz_d = (divisor == '0);
`ifdef SEQ_DIV_SIGNED_EN
          sq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sr_d  = dividend[WIDTH-1];
`endif
        end
      end
      RUN: begin
        p_d   = fin_p;
        qr_d  = fin_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
`ifdef SEQ_DIV_SIGNED_EN
          // A zero divisor keeps the all-ones quotient (-1) unnegated.
          quo_d = (sq_q && !dbz_q) ? -fin_q : fin_q;
          rem_d = sr_q ? -fin_p : fin_p;
`else
          quo_d = fin_q;
          rem_d = fin_p;
`endif
          dbz_out_d = dbz_q;
        end
      end
      default: ;
    endcase
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_seq_restoring_div.sv
// Directed bench for seq_restoring_div, WIDTH=8: instance 0 uses one bit per
// cycle, instance 1 uses two bits per cycle.
module tb_seq_restoring_div;

  logic       clk;
  logic       rst;
  logic       in_valid    [2];
  logic       in_ready    [2];
  logic [7:0] dividend    [2];
  logic [7:0] divisor     [2];
  logic       out_valid   [2];
  logic       out_ready   [2];
  logic [7:0] quotient    [2];
  logic [7:0] remainder   [2];
  logic       div_by_zero [2];

  int checks = 0;
  int errors = 0;

  seq_restoring_div #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .dividend(dividend[0]), .divisor(divisor[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .quotient(quotient[0]), .remainder(remainder[0]),
    .div_by_zero(div_by_zero[0])
  );

  seq_restoring_div #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .dividend(dividend[1]), .divisor(divisor[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .quotient(quotient[1]), .remainder(remainder[1]),
    .div_by_zero(div_by_zero[1])
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept one operation, measure latency, check the result, then complete
  // the output handshake.
  task automatic run_op(input int s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edbz, input int elat, input string nm);
    int w;
    int j;
    w = 0;
    @(negedge clk);
    while (!in_ready[s] && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!in_ready[s]) begin
      errors++;
      $display("FAIL %s in_ready timeout got %0b exp 1", nm, in_ready[s]);
      return;
    end
    dividend[s] = a;
    divisor[s]  = b;
    in_valid[s] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[s] = 1'b0;
    dividend[s] = 8'h5a;
    divisor[s]  = 8'h03;
    j = 0;
    @(negedge clk);
    while (!out_valid[s] && j < 100) begin
      @(negedge clk);
      j++;
    end
    checks++;
    if (j !== elat) begin
      errors++;
      $display("FAIL %s latency got %0d exp %0d", nm, j, elat);
      if (!out_valid[s]) return;
    end
    checks++;
    if (quotient[s] !== eq) begin
      errors++;
      $display("FAIL %s quotient got %0h exp %0h", nm, quotient[s], eq);
    end
    checks++;
    if (remainder[s] !== er) begin
      errors++;
      $display("FAIL %s remainder got %0h exp %0h", nm, remainder[s], er);
    end
    checks++;
    if (div_by_zero[s] !== edbz) begin
      errors++;
      $display("FAIL %s div_by_zero got %0b exp %0b", nm, div_by_zero[s], edbz);
    end
    out_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (in_ready[s] !== 1'b1) begin
        errors++; $display("FAIL reset_in_ready[%0d] got %0b exp 1", s, in_ready[s]);
      end
      checks++;
      if (out_valid[s] !== 1'b0) begin
        errors++; $display("FAIL reset_out_valid[%0d] got %0b exp 0", s, out_valid[s]);
      end
      checks++;
      if (quotient[s] !== 8'h00) begin
        errors++; $display("FAIL reset_quotient[%0d] got %0h exp 0", s, quotient[s]);
      end
      checks++;
      if (remainder[s] !== 8'h00) begin
        errors++; $display("FAIL reset_remainder[%0d] got %0h exp 0", s, remainder[s]);
      end
      checks++;
      if (div_by_zero[s] !== 1'b0) begin
        errors++; $display("FAIL reset_dbz[%0d] got %0b exp 0", s, div_by_zero[s]);
      end
    end
  endtask

  task automatic test_bpc1();
    run_op(0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8, "bpc1_100_7");
  endtask

  task automatic test_bpc2();
`ifdef SEQ_DIV_SIGNED_EN
    run_op(1, 8'd255, 8'd16, 8'h00, 8'hff, 1'b0, 4, "bpc2_m1_16");
`else
    run_op(1, 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 4, "bpc2_255_16");
`endif
    run_op(1, 8'd200, 8'd200, 8'd1, 8'd0, 1'b0, 4, "bpc2_200_200");
  endtask

  task automatic test_div_by_zero();
    run_op(0, 8'd55, 8'd0, 8'hff, 8'd55, 1'b0 | 1'b1, 8, "dbz_55_0");
    run_op(1, 8'd55, 8'd0, 8'hff, 8'd55, 1'b1, 4, "dbz_bpc2_55_0");
  endtask

  task automatic test_msb_divisor();
`ifdef SEQ_DIV_SIGNED_EN
    run_op(0, 8'hff, 8'h80, 8'h00, 8'hff, 1'b0, 8, "msb_m1_m128");
`else
    run_op(0, 8'hff, 8'h80, 8'h01, 8'h7f, 1'b0, 8, "msb_255_128");
`endif
  endtask

  // Result held under backpressure while new operands are offered and ignored.
  task automatic test_backpressure();
    int j;
    @(negedge clk);
    dividend[0] = 8'd50;
    divisor[0]  = 8'd8;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    j = 0;
    @(negedge clk);
    while (!out_valid[0] && j < 100) begin
      @(negedge clk);
      j++;
    end
    checks++;
    if (j !== 8) begin
      errors++; $display("FAIL bp_latency got %0d exp 8", j);
    end
    dividend[0] = 8'd77;
    divisor[0]  = 8'd5;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d out_valid/in_ready got %0b/%0b exp 1/0",
                 c, out_valid[0], in_ready[0]);
      end
      checks++;
      if (quotient[0] !== 8'd6 || remainder[0] !== 8'd2) begin
        errors++;
        $display("FAIL bp_data_%0d got q=%0d r=%0d exp q=6 r=2", c, quotient[0], remainder[0]);
      end
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release in_ready/out_valid got %0b/%0b exp 1/0", in_ready[0], out_valid[0]);
    end
    checks++;
    if (quotient[0] !== 8'd6 || remainder[0] !== 8'd2) begin
      errors++;
      $display("FAIL bp_keep got q=%0d r=%0d exp q=6 r=2", quotient[0], remainder[0]);
    end
  endtask

  task automatic test_back_to_back();
    run_op(0, 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 8, "b2b_9_3");
  endtask

  // Reset three RUN steps into an op, then run a fresh one.
  task automatic test_reset_mid_op();
    @(negedge clk);
    dividend[0] = 8'd100;
    divisor[0]  = 8'd7;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid in_ready/out_valid got %0b/%0b exp 1/0", in_ready[0], out_valid[0]);
    end
    checks++;
    if (quotient[0] !== 8'd0 || remainder[0] !== 8'd0 || div_by_zero[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_data got q=%0h r=%0h dbz=%0b exp 0/0/0",
               quotient[0], remainder[0], div_by_zero[0]);
    end
    run_op(0, 8'd20, 8'd6, 8'd3, 8'd2, 1'b0, 8, "after_rst_20_6");
  endtask

`ifdef SEQ_DIV_SIGNED_EN
  task automatic test_signed();
    run_op(0, 8'hf9, 8'h02, 8'hfd, 8'hff, 1'b0, 8, "s_m7_2");
    run_op(0, 8'h80, 8'hff, 8'h80, 8'h00, 1'b0, 8, "s_min_m1");
    run_op(1, 8'hf9, 8'h00, 8'hff, 8'hf9, 1'b1, 4, "s_m7_0");
  endtask
`endif

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      in_valid[s]  = 1'b0;
      out_ready[s] = 1'b0;
      dividend[s]  = 8'h00;
      divisor[s]   = 8'h00;
    end
    test_reset();
    test_bpc1();
    test_bpc2();
    test_div_by_zero();
    test_msb_divisor();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
`ifdef SEQ_DIV_SIGNED_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_restoring_div.md
Name: seq_restoring_div

Overview:
Iterative restoring divider built from a row of subtract-and-select bit cells (A + ~B + Cin, then keep the difference or restore A). It resolves BITS_PER_CYCLE quotient bits per clock and uses a valid/ready handshake on both sides. It sits in the FPU division path and feeds the mantissa-divide stage with an unsigned quotient and remainder.

Parameters:
WIDTH, 24, dividend/divisor/quotient/remainder width in bits (>=2)
BITS_PER_CYCLE, 1, quotient bits resolved per clock; must divide WIDTH evenly (1, 2, 3, 4 supported)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
dividend  input  WIDTH  numerator
divisor  input  WIDTH  denominator
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  WIDTH  quotient
remainder  output  WIDTH  remainder
div_by_zero  output  1  divisor was zero for this result

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0. Reset wins over every other event, including mid-RUN and mid-DONE. The partial result is discarded.
- States:
  - IDLE -> RUN on accept (in_valid && in_ready).
  - RUN -> DONE after N=WIDTH/BITS_PER_CYCLE RUN cycles.
  - DONE -> IDLE on out_valid && out_ready.
- in_ready = (state==IDLE). Operands are registered at accept. Later operand changes have no effect.
- Accept at edge k: registers load partial remainder P=0, shift register Q=dividend, D=divisor, step counter=0, dbz=(divisor==0).
- Each RUN edge, repeated BITS_PER_CYCLE times combinationally:
  - {P,Q} shift left 1.
  - T = P(WIDTH+1 bits) + ~{0,D} + 1.
  - If there is no borrow (carry-out=1): P=T[WIDTH-1:0] and the new Q LSB = 1.
  - Otherwise P is restored and the new Q LSB = 0.
- Timing: the counter increments each RUN edge. At edge k+N the outputs are loaded and state=DONE, so out_valid=1 in the cycle after edge k+N.
- In DONE, quotient/remainder/div_by_zero are held stable while out_valid=1 and out_ready=0, for an unbounded time.
- Handshake completes at edge where out_valid && out_ready. That edge returns to IDLE; in_ready=1 the next cycle. out_valid drops; data outputs keep their last value.
- Divide by zero needs no special path: the algorithm naturally yields quotient=all ones and remainder=dividend. div_by_zero=1 and latency is unchanged.
- in_valid during RUN/DONE is ignored (in_ready=0). No combinational path from in_valid or out_ready to any output.
- P is WIDTH+1 bits internally so divisors with MSB set are handled.

Optional Feature:
SEQ_DIV_SIGNED_EN:
- Defined: operands are two's complement.
  - At accept, magnitudes |dividend| and |divisor| are loaded. Sign flags sq = sign(dividend)^sign(divisor) and sr = sign(dividend) are registered.
  - At the final RUN edge, quotient is negated if sq and remainder is negated if sr. Quotient truncates toward zero; remainder takes the dividend's sign. Latency is unchanged.
  - MIN/-1 gives quotient=MIN, remainder=0.
  - Divide by zero gives quotient=all ones (-1), remainder=dividend, div_by_zero=1.
- Undefined: unsigned only, no sign logic.

Decomposition:
- Package seq_div_pkg: state enum (IDLE, RUN, DONE) and a localparam function computing counter width clog2(WIDTH/BITS_PER_CYCLE + 1).
- Sub-module div_row: combinational WIDTH+1-cell subtract-and-select row.
  - Inputs: P, next shifted bit, D.
  - Outputs: new P, quotient bit.
  - Instantiated BITS_PER_CYCLE times in a chain.

Test Plan:
- WIDTH=8, BPC=1: accept 100/7 -> out_valid exactly 8 RUN cycles later, quotient=14, remainder=2, div_by_zero=0.
- WIDTH=8, BPC=2: 255/16 -> out_valid after 4 RUN cycles, quotient=15, remainder=15. Also 200/200 -> quotient=1, remainder=0.
- Divide by zero, WIDTH=8: 55/0 -> quotient=0xFF, remainder=55, div_by_zero=1, same 8-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored. Raise out_ready -> in_ready=1 the next cycle. A back-to-back 9/3 then gives quotient=3, remainder=0.
- Reset mid-op: assert rst at RUN step 3 -> next cycle in_ready=1, out_valid=0, outputs zero. A fresh 20/6 then gives quotient=3, remainder=2.
- SEQ_DIV_SIGNED_EN, WIDTH=8: -7/2 -> quotient=0xFD, remainder=0xFF. Also 0x80/0xFF -> quotient=0x80, remainder=0.
